// File: rtl/sap_ctrl_pkg.sv
// rtl/sap_ctrl_pkg.sv - shared constants, control-word bit map and stage encodings for the SAP sequencer
//
// Purpose: one place for opcode values, control-word bit indices, the
// idle (NOP) control word and the T-state encodings seen on the stage port.
// Ports: none (package).
package sap_ctrl_pkg;

    localparam int CTRL_W = 15;

    // Opcodes as they appear in IR[7:4]
    localparam logic [3:0] OP_HLT = 4'h0;
    localparam logic [3:0] OP_NOP = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_LDA = 4'h4;
    localparam logic [3:0] OP_OUT = 4'h5;
    localparam logic [3:0] OP_STA = 4'h6;
    localparam logic [3:0] OP_JMP = 4'h7;

    // Control-word bit indices; *_N bits are active-low datapath pins
    localparam int SIG_OUT_LOAD_N      = 0;
    localparam int SIG_B_LOAD_N        = 1;
    localparam int SIG_ALU_EN          = 2;
    localparam int SIG_ADDER_SUB       = 3;
    localparam int SIG_A_EN            = 4;
    localparam int SIG_A_LOAD_N        = 5;
    localparam int SIG_IR_EN_N         = 6;
    localparam int SIG_IR_LOAD_N       = 7;
    localparam int SIG_RAM_WE_N        = 8;
    localparam int SIG_RAM_EN_N        = 9;
    localparam int SIG_RAM_DATA_LOAD_N = 10;
    localparam int SIG_MAR_ADDR_LOAD_N = 11;
    localparam int SIG_PC_LOAD         = 12;
    localparam int SIG_PC_EN           = 13;
    localparam int SIG_PC_INC          = 14;

    // Every signal deasserted: active-low pins high, active-high pins low
    localparam logic [CTRL_W-1:0] CTRL_NOP = 15'h0FE3;

    typedef enum logic [2:0] {
        ST_T0   = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_T3   = 3'd3,
        ST_T4   = 3'd4,
        ST_T5   = 3'd5,
        ST_WAIT = 3'd6,
        ST_HALT = 3'd7
    } stage_e;

    // One-hot mask for a single control signal
    function automatic logic [CTRL_W-1:0] sig(input int idx);
        logic [CTRL_W-1:0] m;
        m      = '0;
        m[idx] = 1'b1;
        return m;
    endfunction

    // Asserting a signal means flipping it away from its idle level, so an
    // XOR against the NOP word handles active-high and active-low pins alike.
    function automatic logic [CTRL_W-1:0] ctrl_word(input logic [CTRL_W-1:0] asserted);
        return CTRL_NOP ^ asserted;
    endfunction

endpackage

// File: rtl/sap_microsequencer_if.sv
// rtl/sap_microsequencer_if.sv - opcode/mode inputs and control outputs of the SAP sequencer
//
// Purpose: bundles the sequencer's non-clock signals.
// Signals: opcode[3:0], run_mode, step (driven by master);
//          ctrl[14:0], stage[2:0], halted, instr_done (driven by slave).
interface sap_microsequencer_if;
    import sap_ctrl_pkg::*;

    logic [3:0]        opcode;
    logic              run_mode;
    logic              step;
    logic [CTRL_W-1:0] ctrl;
    logic [2:0]        stage;
    logic              halted;
    logic              instr_done;

    modport master (
        output opcode, run_mode, step,
        input  ctrl, stage, halted, instr_done
    );

    modport slave (
        input  opcode, run_mode, step,
        output ctrl, stage, halted, instr_done
    );

endinterface

// File: rtl/sap_microcode_rom.sv
// rtl/sap_microcode_rom.sv - combinational microcode: (stage, opcode) -> control word and last-stage flag
//
// Purpose: holds the fetch and execute control words for every instruction.
// Ports: stage  in  current T-state (WAIT/HALT give NOP)
//        opcode in  live opcode at T3, latched opcode at T4/T5
//        ctrl   out control word
//        last   out this stage ends the instruction (never set for HLT)
module sap_microcode_rom
    import sap_ctrl_pkg::*;
(
    input  stage_e            stage,
    input  logic [3:0]        opcode,
    output logic [CTRL_W-1:0] ctrl,
    output logic              last
);

    always_comb begin
        ctrl = CTRL_NOP;
        last = 1'b0;
        case (stage)
            ST_T0: ctrl = ctrl_word(sig(SIG_PC_EN) | sig(SIG_MAR_ADDR_LOAD_N));
            ST_T1: ctrl = ctrl_word(sig(SIG_PC_INC));
            ST_T2: ctrl = ctrl_word(sig(SIG_RAM_EN_N) | sig(SIG_IR_LOAD_N));
            ST_T3: begin
                case (opcode)
                    OP_HLT: last = 1'b0;
                    OP_LDA, OP_ADD, OP_SUB, OP_STA:
                        ctrl = ctrl_word(sig(SIG_IR_EN_N) | sig(SIG_MAR_ADDR_LOAD_N));
                    OP_OUT: begin
                        ctrl = ctrl_word(sig(SIG_A_EN) | sig(SIG_OUT_LOAD_N));
                        last = 1'b1;
                    end
                    OP_JMP: begin
                        ctrl = ctrl_word(sig(SIG_IR_EN_N) | sig(SIG_PC_LOAD));
                        last = 1'b1;
                    end
                    default: last = 1'b1;
                endcase
            end
            ST_T4: begin
                case (opcode)
                    OP_LDA: begin
                        ctrl = ctrl_word(sig(SIG_RAM_EN_N) | sig(SIG_A_LOAD_N));
                        last = 1'b1;
                    end
                    OP_ADD, OP_SUB:
                        ctrl = ctrl_word(sig(SIG_RAM_EN_N) | sig(SIG_B_LOAD_N));
                    OP_STA:
                        ctrl = ctrl_word(sig(SIG_A_EN) | sig(SIG_RAM_DATA_LOAD_N));
                    // Unreachable for other opcodes; ending here keeps the FSM safe
                    default: last = 1'b1;
                endcase
            end
            ST_T5: begin
                last = 1'b1;
                case (opcode)
                    OP_ADD: ctrl = ctrl_word(sig(SIG_ALU_EN) | sig(SIG_A_LOAD_N));
                    OP_SUB: ctrl = ctrl_word(sig(SIG_ALU_EN) | sig(SIG_ADDER_SUB) | sig(SIG_A_LOAD_N));
                    OP_STA: ctrl = ctrl_word(sig(SIG_RAM_WE_N));
                    default: ctrl = CTRL_NOP;
                endcase
            end
            default: ctrl = CTRL_NOP;
        endcase
    end

endmodule

// File: rtl/sap_microsequencer.sv
// rtl/sap_microsequencer.sv - T-state sequencer for the 8-bit SAP CPU
//
// Purpose: steps WAIT/T0..T5/HALT, latches the opcode, detects step
// triggers and decodes the control word through the microcode ROM.
// Ports: clk, rst_n (synchronous, active-low)
//        bus.opcode/run_mode/step  in
//        bus.ctrl/stage/halted/instr_done  out
// Parameter: STEP_EDGE 1 = step acts on its rising edge, 0 = level.
module sap_microsequencer
    import sap_ctrl_pkg::*;
#(
    parameter bit STEP_EDGE = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sap_microsequencer_if.slave   bus
);

    stage_e            state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic              step_q, step_d;
    logic              step_trig;
    logic              is_hlt;
    logic [3:0]        rom_op;
    logic [CTRL_W-1:0] rom_ctrl;
    logic              rom_last;

    // The opcode register only becomes valid at the end of T3, so T3 itself
    // must decode the live IR field.
    assign rom_op = (state_q == ST_T3) ? bus.opcode : op_q;

    sap_microcode_rom u_rom (
        .stage  (state_q),
        .opcode (rom_op),
        .ctrl   (rom_ctrl),
        .last   (rom_last)
    );

    always_comb begin
        step_d    = bus.step;
        step_trig = STEP_EDGE ? (bus.step & ~step_q) : bus.step;
        op_d      = (state_q == ST_T3) ? bus.opcode : op_q;
        is_hlt    = (state_q == ST_T3) && (bus.opcode == OP_HLT);
        state_d   = state_q;
        case (state_q)
            ST_WAIT: if (bus.run_mode || step_trig) state_d = ST_T0;
            ST_T0:   state_d = ST_T1;
            ST_T1:   state_d = ST_T2;
            ST_T2:   state_d = ST_T3;
            ST_T3, ST_T4, ST_T5: begin
                if (is_hlt)
                    state_d = ST_HALT;
                else if (rom_last)
                    // run_mode only matters here, at the instruction boundary
                    state_d = bus.run_mode ? ST_T0 : ST_WAIT;
                else if (state_q == ST_T3)
                    state_d = ST_T4;
                else if (state_q == ST_T4)
                    state_d = ST_T5;
                else
                    state_d = ST_WAIT;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_WAIT;
            op_q    <= 4'h0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            step_q  <= step_d;
        end
    end

    assign bus.ctrl       = rom_ctrl;
    assign bus.stage      = state_q;
    assign bus.halted     = (state_q == ST_HALT);
    assign bus.instr_done = rom_last;

endmodule
